// File: rtl/sad_min_selector.sv
// Block-matching minimum selector: sums ROWS row-SADs per search candidate and keeps the
// lowest block SAD with its motion vector, then offers the result over a valid/ready handshake.
module sad_min_selector #(
  parameter int ROWS  = 16,
  parameter int RANGE = 8,
  parameter int SW    = 12 + $clog2(ROWS),
  parameter int MW    = $clog2(RANGE) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          sad_valid,
  input  logic [11:0]   sad_in,
  output logic          sad_ready,
  output logic          mv_valid,
  input  logic          mv_ready,
  output logic [MW-1:0] mv_x,
  output logic [MW-1:0] mv_y,
  output logic [SW-1:0] min_sad
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = 2 * MW;  // candidate index = {dy field, dx field}
  localparam logic [MW-1:0] OFS      = MW'(RANGE);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_cand;
  logic [SW-1:0] r_acc;
  logic [SW-1:0] r_min;
  logic [MW-1:0] r_best_x;
  logic [MW-1:0] r_best_y;
  logic          r_sad_ready;
  logic          r_mv_valid;

  logic          w_beat;
  logic          w_last_row;
  logic          w_last_cand;
  logic          w_better;
  logic [SW-1:0] w_total;
  logic [MW-1:0] w_dx;
  logic [MW-1:0] w_dy;

  assign w_beat      = sad_valid && r_sad_ready;
  assign w_last_row  = (r_row == LAST_ROW);
  assign w_last_cand = &r_cand;
  assign w_total     = r_acc + SW'(sad_in);
  // Strict compare keeps the earlier candidate on ties; candidate 0 always seeds the minimum.
  assign w_better    = (w_total < r_min) || (r_cand == '0);
  // Field minus RANGE wraps into the signed range -RANGE..RANGE-1.
  assign w_dx        = r_cand[MW-1:0] - OFS;
  assign w_dy        = r_cand[CW-1:MW] - OFS;

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_cand      <= '0;
      r_acc       <= '0;
      r_min       <= '0;
      r_best_x    <= '0;
      r_best_y    <= '0;
      r_sad_ready <= 1'b0;
      r_mv_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_ACC;
            r_row       <= '0;
            r_cand      <= '0;
            r_acc       <= '0;
            r_min       <= '1;
            r_best_x    <= OFS;
            r_best_y    <= OFS;
            r_sad_ready <= 1'b1;
          end
        end
        S_ACC: begin
          if (w_beat) begin
            if (w_last_row) begin
              if (w_better) begin
                r_min    <= w_total;
                r_best_x <= w_dx;
                r_best_y <= w_dy;
              end
              r_acc  <= '0;
              r_row  <= '0;
              r_cand <= r_cand + CW'(1);
              if (w_last_cand) begin
                r_state     <= S_DONE;
                r_sad_ready <= 1'b0;
                r_mv_valid  <= 1'b1;
              end
            end else begin
              r_acc <= w_total;
              r_row <= r_row + RW'(1);
            end
          end
        end
        S_DONE: begin
          if (mv_ready) begin
            r_state    <= S_IDLE;
            r_mv_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_sad_ready <= 1'b0;
          r_mv_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign sad_ready = r_sad_ready;
  assign mv_valid  = r_mv_valid;
  assign mv_x      = r_best_x;
  assign mv_y      = r_best_y;
  assign min_sad   = r_min;

endmodule

// File: tb/tb_sad_min_selector.sv
// Directed bench for sad_min_selector: full searches with known minima, ties, extreme values,
// stalls, backpressure and an asynchronous reset in the middle of a search.
module tb_sad_min_selector;

  localparam int NB = 4096;  // 16 rows x 256 candidates

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        sad_valid = 1'b0;
  logic [11:0] sad_in = '0;
  logic        sad_ready;
  logic        mv_valid;
  logic        mv_ready = 1'b0;
  logic [3:0]  mv_x;
  logic [3:0]  mv_y;
  logic [15:0] min_sad;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sad_min_selector dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sad_valid (sad_valid),
    .sad_in    (sad_in),
    .sad_ready (sad_ready),
    .mv_valid  (mv_valid),
    .mv_ready  (mv_ready),
    .mv_x      (mv_x),
    .mv_y      (mv_y),
    .min_sad   (min_sad)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Row SAD for beat b of scenario s.
  function automatic logic [11:0] row_val(input int s, input int b);
    case (s)
      0:       row_val = (b >= 1712 && b <= 1727) ? 12'd2 : 12'd10;
      1:       row_val = 12'd5;
      2:       row_val = 12'd4095;
      default: row_val = (b >= NB - 16) ? 12'd4094 : 12'd4095;
    endcase
  endfunction

  task automatic check_result(input string tag, input int exp_sad, input int exp_x, input int exp_y);
    check({tag, "_min_sad"}, int'(min_sad), exp_sad);
    check({tag, "_mv_x"}, int'($signed(mv_x)), exp_x);
    check({tag, "_mv_y"}, int'($signed(mv_y)), exp_y);
  endtask

  // Pulses start, then streams beats until stop_at have transferred (bounded by a cycle budget).
  task automatic run_search(input int scen, input bit gaps, input int stop_at, output int lat);
    int  beat;
    int  cyc;
    bit  v;
    bit  xfer;
    beat = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    while (beat < stop_at && cyc < 20000) begin
      @(negedge clk);
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      sad_valid = v;
      sad_in    = row_val(scen, beat);
      xfer      = v && sad_ready;
      @(posedge clk);
      cyc++;
      if (xfer) beat++;
    end
    #1 sad_valid = 1'b0;
    check("beats_accepted", beat, stop_at);
    lat = cyc;
  endtask

  task automatic handshake();
    @(negedge clk);
    mv_ready = 1'b1;
    @(posedge clk);
    #1 check("idle_after_handshake", int'(mv_valid), 0);
    mv_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [15:0] held_sad;

    // Reset state
    #12;
    check("rst_sad_ready", int'(sad_ready), 0);
    check("rst_mv_valid", int'(mv_valid), 0);
    check_result("rst", 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    // Unique minimum at candidate 107 -> (3,-2), continuous input
    run_search(0, 1'b0, NB, lat);
    check("s0_mv_valid", int'(mv_valid), 1);
    check("s0_latency", lat, 4097);
    check("s0_sad_ready_done", int'(sad_ready), 0);
    check_result("s0", 32, 3, -2);
    handshake();
    check_result("s0_held", 32, 3, -2);

    // All-equal ties keep candidate 0; mv_ready already high before mv_valid
    mv_ready = 1'b1;
    run_search(1, 1'b0, NB, lat);
    check("s1_mv_valid", int'(mv_valid), 1);
    check_result("s1", 80, -8, -8);
    @(posedge clk);
    #1 check("s1_early_ready_idle", int'(mv_valid), 0);
    mv_ready = 1'b0;

    // Maximum row values
    run_search(2, 1'b0, NB, lat);
    check_result("s2", 65520, -8, -8);
    handshake();
    run_search(3, 1'b0, NB, lat);
    check_result("s3", 65504, 7, 7);
    handshake();

    // Stalled input, then backpressure with stray sad_valid/start pulses
    run_search(0, 1'b1, NB, lat);
    check("s4_mv_valid", int'(mv_valid), 1);
    check_result("s4", 32, 3, -2);
    held_sad = min_sad;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sad_valid = 1'b1;
      sad_in    = 12'd0;
      start     = (i % 2 == 0);
      @(posedge clk);
      #1;
      check("bp_mv_valid", int'(mv_valid), 1);
      check("bp_sad_ready", int'(sad_ready), 0);
      check("bp_min_sad", int'(min_sad), int'(held_sad));
    end
    check_result("bp_end", 32, 3, -2);
    // Start coincident with the handshake is ignored
    @(negedge clk);
    sad_valid = 1'b0;
    start     = 1'b1;
    mv_ready  = 1'b1;
    @(posedge clk);
    #1;
    check("bp_idle", int'(mv_valid), 0);
    start    = 1'b0;
    mv_ready = 1'b0;
    @(posedge clk);
    #1 check("bp_start_ignored", int'(sad_ready), 0);
    check_result("bp_held", 32, 3, -2);

    // Asynchronous reset after 100 beats, then a clean restart
    run_search(0, 1'b0, 100, lat);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_sad_ready", int'(sad_ready), 0);
    check("arst_mv_valid", int'(mv_valid), 0);
    check_result("arst", 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 check("arst_idle", int'(sad_ready), 0);
    run_search(0, 1'b0, NB, lat);
    check("restart_mv_valid", int'(mv_valid), 1);
    check("restart_latency", lat, 4097);
    check_result("restart", 32, 3, -2);
    handshake();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sad_min_selector.md
# sad_min_selector

Consumer of the PE array's per-row SAD stream for full-search block matching. It accumulates ROWS row-SADs into one block SAD per search candidate and tracks the minimum over a raster-ordered search window. It then presents the winning motion vector and its SAD through a valid/ready handshake. It sits directly downstream of the PE row-SAD outputs and upstream of motion-vector storage.

## Interface
- ROWS, 16: row-SADs per candidate block; power of two.
- RANGE, 8: search offsets per axis run from -RANGE to RANGE-1, giving 2·RANGE·2·RANGE candidates (256 by default).
- SW, 12+$clog2(ROWS) = 16: block-SAD width.
- MW, $clog2(RANGE)+1 = 4: signed motion-vector component width.

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- start  in  1  one-cycle pulse that begins a search; honoured only in IDLE.
- sad_valid  in  1  sad_in is valid this cycle.
- sad_in  in  12  unsigned row SAD from the PE.
- sad_ready  out  1  block accepts a row SAD; a beat transfers when sad_valid && sad_ready.
- mv_valid  out  1  result is valid.
- mv_ready  in  1  downstream accepts the result.
- mv_x  out  MW  signed horizontal offset of the best candidate.
- mv_y  out  MW  signed vertical offset of the best candidate.
- min_sad  out  SW  block SAD of the best candidate.

## Operation
- FSM states: IDLE, ACC, DONE.
- IDLE behaviour:
  - sad_ready=0, mv_valid=0.
  - On start: row counter=0, candidate counter=0, accumulator=0, min register=all ones, best vector=(-RANGE,-RANGE); next state ACC.
- ACC behaviour:
  - sad_ready=1.
  - Each accepted beat adds sad_in to the accumulator and increments the row counter.
  - On the beat with row counter = ROWS-1, the candidate total is accumulator + sad_in.
  - If total < min (strict), or this is candidate 0, min and the best vector are updated. The accumulator and row counter then clear and the candidate counter increments.
- Candidate order and vector mapping:
  - Candidates are raster-ordered, dy outer and dx inner.
  - Candidate k maps to dx = (k mod 2·RANGE) − RANGE and dy = (k div 2·RANGE) − RANGE.
  - Ties keep the earlier candidate.
- ACC exit: after the final row of the last candidate, the next state is DONE.
- DONE behaviour:
  - mv_valid=1; mv_x, mv_y and min_sad hold stable; sad_ready=0.
  - On mv_valid && mv_ready: next state IDLE, mv_valid drops to 0, and the output data hold their values.
- Ignored inputs: start outside IDLE has no effect. sad_valid while sad_ready=0 has no effect and is not counted.
- Arithmetic: unsigned SW-bit accumulation. ROWS·4095 fits in SW bits, so no saturation or wrap occurs.
- Reset, at power-up or mid-operation: state=IDLE; sad_ready=0, mv_valid=0, mv_x=0, mv_y=0, min_sad=0; all counters and the accumulator cleared. A partial search is discarded.

## Timing
- All outputs are registered.
- sad_ready rises in the cycle after start is sampled.
- Input throughput is one row-SAD per cycle with no bubbles required. Gaps in sad_valid only stall accumulation.
- mv_valid rises in the cycle after the last beat is accepted. Minimum start-to-mv_valid latency is 1 + ROWS·(2·RANGE)² cycles (4097 by default).
- The result is held indefinitely under mv_ready=0.
- mv_ready may be high before mv_valid rises. The handshake then completes in the first mv_valid cycle, and the block is in IDLE in the next cycle.
- A start coinciding with the handshake cycle is ignored. A new start is accepted only once the block is in IDLE.

## Test plan
- Defaults, unique minimum:
  - Stimulus: all rows = 10, except candidate k=107 with rows = 2 (beats 1712..1727).
  - Required: min_sad=32, mv_x=3, mv_y=-2, mv_valid exactly 4097 cycles after start with continuous valid.
- All-equal ties:
  - Stimulus: every row = 5.
  - Required: min_sad=80, mv=(-8,-8).
- Maximum values:
  - Stimulus: every row = 4095, then a separate run with the last candidate's rows = 4094.
  - Required: first run min_sad=65520, mv=(-8,-8). Second run min_sad=65504, mv=(7,7).
- Stalls and backpressure:
  - Stimulus: repeat the first scenario with random sad_valid gaps, then hold mv_ready=0 for 10 cycles while pulsing sad_valid and start.
  - Required: identical result; outputs stable; sad_ready=0 throughout DONE; IDLE one cycle after mv_ready=1.
- Reset mid-search:
  - Stimulus: reset=0 asynchronously after 100 beats, then a new start.
  - Required: outputs immediately 0, state IDLE; the restarted first-scenario search returns (3,-2, 32).
